// File: rtl/aia_pkg.sv
// Shared AIA types and sizing for the APLIC MSI sender.
// Holds the MSI request bundle, sender FSM states and IMSIC constants.
package aia_pkg;

  localparam int unsigned UserNrHarts        = 5;
  localparam int unsigned UserNrSourcesImsic = 256;
  localparam int unsigned UserNrVSIntpFiles  = 1;
  localparam int unsigned UserXLEN           = 64;

  localparam int unsigned ReqHartW  = $clog2(UserNrHarts);
  localparam int unsigned ReqEiidW  = $clog2(UserNrSourcesImsic);
  localparam int unsigned ReqGuestW = $clog2(UserNrVSIntpFiles + 1);

  localparam int unsigned PpnW             = 44;
  localparam int unsigned IMSIC_PAGE_SHIFT = 12;

  typedef struct packed {
    logic                 domain;
    logic [ReqHartW-1:0]  hart;
    logic [ReqGuestW-1:0] guest;
    logic [ReqEiidW-1:0]  eiid;
  } msi_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP
  } msi_state_e;

endpackage

// File: rtl/aplic_msi_fifo.sv
// Synchronous request FIFO of msi_req_t (push/pop, full/empty).
// Ports: clk_i, rst_ni, push_i, pop_i, data_i, data_o, full_o, empty_o.
module aplic_msi_fifo
  import aia_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  msi_req_t data_i,
  output msi_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  msi_req_t        mem_q [Depth];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = cnt_q == (PtrW+1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/aplic_msi_sender.sv
// APLIC MSI-mode sender: buffers forwarded interrupts, writes MSIs to IMSICs.
// Ports: req_* in, msi_* write/response, base PPNs, busy and drop/err counts.
module aplic_msi_sender
  import aia_pkg::*;
#(
  parameter  int unsigned NrHarts       = UserNrHarts,
  parameter  int unsigned NrSources     = UserNrSourcesImsic,
  parameter  int unsigned NrVSIntpFiles = UserNrVSIntpFiles,
  parameter  int unsigned XLEN          = UserXLEN,
  parameter  int unsigned FifoDepth     = 4,
  localparam int unsigned HartW         = $clog2(NrHarts),
  localparam int unsigned EiidW         = $clog2(NrSources),
  localparam int unsigned GuestW        = $clog2(NrVSIntpFiles + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_domain_i,
  input  logic [HartW-1:0]  req_hart_i,
  input  logic [GuestW-1:0] req_guest_i,
  input  logic [EiidW-1:0]  req_eiid_i,
  input  logic [PpnW-1:0]   mbase_ppn_i,
  input  logic [PpnW-1:0]   sbase_ppn_i,
  output logic              msi_valid_o,
  input  logic              msi_ready_i,
  output logic [XLEN-1:0]   msi_addr_o,
  output logic [31:0]       msi_data_o,
  input  logic              msi_bvalid_i,
  input  logic [1:0]        msi_bresp_i,
  output logic              msi_bready_o,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o,
  output logic [7:0]        err_cnt_o
);

  msi_state_e      state_q;
  msi_state_e      state_d;
  msi_req_t        req_in;
  msi_req_t        head;
  logic            full;
  logic            empty;
  logic            pop;
  logic            entry_ok;
  logic [PpnW-1:0] ppn_sum;
  logic [XLEN-1:0] addr_d;
  logic            valid_q;
  logic [XLEN-1:0] addr_q;
  logic [31:0]     data_q;
  logic [7:0]      drop_q;
  logic [7:0]      err_q;

  assign req_in = '{
    domain: req_domain_i,
    hart:   req_hart_i,
    guest:  req_guest_i,
    eiid:   req_eiid_i
  };

  aplic_msi_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (req_valid_i),
    .pop_i  (pop),
    .data_i (req_in),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign req_ready_o  = !full;
  assign pop          = (state_q == IDLE) && !empty;
  assign msi_bready_o = state_q == WAIT_RESP;
  assign busy_o       = !empty || (state_q != IDLE);
  assign msi_valid_o  = valid_q;
  assign msi_addr_o   = addr_q;
  assign msi_data_o   = data_q;
  assign drop_cnt_o   = drop_q;
  assign err_cnt_o    = err_q;

  assign entry_ok = (head.eiid != '0)
                 && (32'(head.hart) < NrHarts)
                 && !(head.domain
                      && (32'(head.guest) > NrVSIntpFiles));

  // Bases are sampled here, at pop time; the sum wraps at 44 bits.
  always_comb begin
    if (head.domain) begin
      ppn_sum = sbase_ppn_i
              + PpnW'(head.hart) * PpnW'(NrVSIntpFiles + 1)
              + PpnW'(head.guest);
    end else begin
      ppn_sum = mbase_ppn_i + PpnW'(head.hart);
    end
  end

  assign addr_d = XLEN'(ppn_sum) << IMSIC_PAGE_SHIFT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pop && entry_ok) state_d = SEND;
      SEND:      if (msi_ready_i) state_d = WAIT_RESP;
      WAIT_RESP: if (msi_bvalid_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d == SEND;
      if (pop && entry_ok) begin
        addr_q <= addr_d;
        data_q <= 32'(head.eiid);
      end
      if (pop && !entry_ok && (drop_q != 8'hff)) begin
        drop_q <= drop_q + 8'd1;
      end
      if ((state_q == WAIT_RESP) && msi_bvalid_i
          && (msi_bresp_i != 2'b00) && (err_q != 8'hff)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

endmodule
